// File: rtl/updown_counter_mod.sv
// Parametrised modulo-MOD up/down counter with parallel load, wrap pulse and one-shot halt.
// Optional step prescaler is built only when COUNTER_PRESCALE_EN is defined.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MOD      = 16,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             done
);

  if (WIDTH < 1 || MOD < 2 || 64'(MOD) > (64'd1 << WIDTH) || PRESCALE < 1) begin : g_bad_cfg
    $error("updown_counter_mod: illegal WIDTH/MOD/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;

  // Terminal tracks the current direction, so a direction flip is seen on the very next step.
  assign at_term      = up ? (q == LAST) : (q == '0);
  assign load_clamped = (load_val > LAST) ? LAST : load_val;
  assign q_inc        = (q == LAST) ? '0 : q + 1'b1;
  assign q_dec        = (q == '0) ? LAST : q - 1'b1;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign step = en && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      pre_cnt <= '0;
    end else if (state == ST_RUN && en) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  assign step = en;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      q     <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      state <= ST_RUN;
      q     <= load_clamped;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_RUN: begin
          if (step) begin
            if (at_term && oneshot) begin
              state <= ST_DONE;
            end else begin
              q    <= up ? q_inc : q_dec;
              wrap <= at_term;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod (WIDTH=4, MOD=10): directed test-plan sequences then random stimulus.
module tb_updown_counter_mod;

  localparam int WIDTH    = 4;
  localparam int MOD      = 10;
  localparam int PRESCALE = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             up = 1'b1;
  logic             oneshot = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             done;

  typedef struct {
    int q;
    bit wrap;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int m_q    = 0;
  bit m_wrap = 0;
  bit m_done = 0;
  int m_pre  = 0;

  updown_counter_mod #(
    .WIDTH   (WIDTH),
    .MOD     (MOD),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .oneshot (oneshot),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .wrap    (wrap),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic bit model_step_now();
`ifdef COUNTER_PRESCALE_EN
    m_pre = m_pre + 1;
    if (m_pre == PRESCALE) begin
      m_pre = 0;
      return 1'b1;
    end
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit u, input bit os);
    bit term;
    exp_t x;
    @(negedge clk);
    reset    = r;
    load     = l;
    load_val = lv[WIDTH-1:0];
    en       = e;
    up       = u;
    oneshot  = os;
    m_wrap   = 0;
    if (r) begin
      m_q = 0; m_done = 0; m_pre = 0;
    end else if (l) begin
      m_q = (lv > MOD - 1) ? MOD - 1 : lv;
      m_done = 0; m_pre = 0;
    end else if (!m_done && e && model_step_now()) begin
      term = u ? (m_q == MOD - 1) : (m_q == 0);
      if (term && os) begin
        m_done = 1;
      end else begin
        m_q    = (m_q + (u ? 1 : MOD - 1)) % MOD;
        m_wrap = term;
      end
    end
    x.q = m_q; x.wrap = m_wrap; x.done = m_done;
    exp_q.push_back(x);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares the DUT outputs after each rising edge against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        cmp("q", int'(q), x.q);
        cmp("wrap", int'(wrap), int'(x.wrap));
        cmp("done", int'(done), int'(x.done));
      end
    end
  end

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    // Count up through the wrap
    repeat (24) cyc(0, 0, 0, 1, 1, 0);
    // Count down from reset through 0 -> 9
    cyc(1, 0, 0, 0, 0, 0);
    repeat (24) cyc(0, 0, 0, 1, 0, 0);
    // Clamped load, one-shot halt, direction flip while halted, reload
    cyc(0, 1, 13, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 1, 1);
    repeat (3) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 3, 1, 1, 1);
    repeat (4) cyc(0, 0, 0, 1, 1, 0);
    // Load beats enable; reset beats load
    cyc(0, 1, 5, 1, 1, 0);
    cyc(1, 1, 7, 1, 1, 0);
    // Enable toggling at q=6, then reset mid-count
    cyc(0, 1, 6, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0);
    // One-shot down at 0, direction flip with continuous enable
    repeat (3) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 9, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, ($urandom_range(0, 1) == 1), 0);
    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
    end
    @(posedge clk);
    #2;
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
